// File: rtl/video_frame_monitor_if.sv
// ---------------------------------------------------------------------------
// video_frame_monitor_if
// Raster video port bundle (vsync / href / de / data) as driven by the
// stitcher's output stage.
//   master modport : source of the stream (drives all four signals)
//   slave  modport : receiver / monitor (samples all four signals)
// Parameter DATA_WIDTH : pixel width in bits.
// ---------------------------------------------------------------------------
interface video_frame_monitor_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  video_vsync;
    logic                  video_href;
    logic                  video_de;
    logic [DATA_WIDTH-1:0] video_data;

    modport master (
        output video_vsync,
        output video_href,
        output video_de,
        output video_data
    );

    modport slave (
        input video_vsync,
        input video_href,
        input video_de,
        input video_data
    );
endinterface

// File: rtl/video_frame_monitor.sv
// ---------------------------------------------------------------------------
// video_frame_monitor
// Passive receive-side monitor for a raster video stream. It measures each
// frame's geometry against IMG_HDISP x IMG_VDISP, flags protocol problems
// and publishes a one-cycle report per completed frame.
//
// Optional feature: define VIDEO_FRAME_MONITOR_CHECKSUM_EN to build the
// 32-bit pixel checksum; otherwise frame_sum is tied to zero.
//
// Ports
//   video_clk     in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   vid           slave video port (vsync, href, de, data)
//   mon_en        in   0 parks the monitor in SYNC_WAIT and drops the frame
//   frame_done    out  one-cycle report strobe
//   frame_ok      out  last reported frame had no error bits
//   err_flags     out  [0] line length, [1] line count, [2] de outside href,
//                      [3] line truncated by vsync
//   frame_cnt     out  reported frames since reset (wraps)
//   last_pix_cnt  out  pixel count of the most recently closed line
//   last_line_cnt out  line count of the last reported frame
//   frame_sum     out  checksum of the last reported frame
// ---------------------------------------------------------------------------
module video_frame_monitor #(
    parameter int IMG_HDISP  = 1920,
    parameter int IMG_VDISP  = 1080,
    parameter int DATA_WIDTH = 24
) (
    input  logic                 video_clk,
    input  logic                 rst,
    video_frame_monitor_if.slave vid,
    input  logic                 mon_en,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [3:0]           err_flags,
    output logic [15:0]          frame_cnt,
    output logic [11:0]          last_pix_cnt,
    output logic [11:0]          last_line_cnt,
    output logic [31:0]          frame_sum
);

    localparam logic [11:0] HDISP   = 12'(IMG_HDISP);
    localparam logic [11:0] VDISP   = 12'(IMG_VDISP);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        ACTIVE,
        REPORT
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // input stage: one register for everything, a second for the edge inputs
    logic r_vs_s1, r_vs_s2;
    logic r_hr_s1, r_hr_s2;
    logic r_de_s1;

    // per-frame working state
    logic [11:0] r_pix_cnt;
    logic [11:0] r_line_cnt;
    logic        r_err_len;
    logic        r_err_stray;
    logic        r_err_trunc;

    logic w_vs_rise, w_hr_fall;
    logic w_pix_acc, w_stray;
    logic [11:0] w_pix_inc;
    logic [11:0] w_line_inc;
    logic w_hr_close, w_vs_close, w_line_close;
    logic [11:0] w_close_len;
    logic w_err_lines;
    logic w_clear, w_run, w_report;

    assign w_vs_rise = r_vs_s1 & ~r_vs_s2;
    assign w_hr_fall = r_hr_s2 & ~r_hr_s1;
    assign w_pix_acc = r_de_s1 & r_hr_s1;
    assign w_stray   = r_de_s1 & ~r_hr_s1;

    assign w_pix_inc  = (w_pix_acc && r_pix_cnt != CNT_MAX) ? r_pix_cnt + 12'd1 : r_pix_cnt;
    assign w_line_inc = (r_line_cnt != CNT_MAX) ? r_line_cnt + 12'd1 : r_line_cnt;

    // An href fall with no pixels is blanking and is not a line. A vsync rise
    // with href still high cuts the line short; the pixel sampled in that same
    // cycle still belongs to it, hence w_pix_inc rather than r_pix_cnt.
    assign w_hr_close   = w_hr_fall && (r_pix_cnt != 12'd0);
    assign w_vs_close   = w_vs_rise && r_hr_s1 && (w_pix_inc != 12'd0);
    assign w_line_close = w_hr_close | w_vs_close;
    assign w_close_len  = w_hr_close ? r_pix_cnt : w_pix_inc;
    assign w_err_lines  = (r_line_cnt != VDISP);

    // ---------------- FSM ----------------
    always_ff @(posedge video_clk) begin
        if (rst) begin
            r_state <= SYNC_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_run        = 1'b0;
        w_report     = 1'b0;
        case (r_state)
            SYNC_WAIT: begin
                w_clear = 1'b1;
                if (w_vs_rise) begin
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                w_run = 1'b1;
                if (w_vs_rise) begin
                    w_state_next = REPORT;
                end
            end
            REPORT: begin
                w_report     = 1'b1;
                w_state_next = ACTIVE;
            end
            default: begin
                w_clear      = 1'b1;
                w_state_next = SYNC_WAIT;
            end
        endcase
        // disabling discards the frame in progress, including a pending report
        if (!mon_en) begin
            w_state_next = SYNC_WAIT;
            w_clear      = 1'b1;
            w_run        = 1'b0;
            w_report     = 1'b0;
        end
    end

    // ---------------- input stage and counters ----------------
    always_ff @(posedge video_clk) begin
        if (rst) begin
            r_vs_s1       <= 1'b0;
            r_vs_s2       <= 1'b0;
            r_hr_s1       <= 1'b0;
            r_hr_s2       <= 1'b0;
            r_de_s1       <= 1'b0;
            r_pix_cnt     <= 12'd0;
            r_line_cnt    <= 12'd0;
            r_err_len     <= 1'b0;
            r_err_stray   <= 1'b0;
            r_err_trunc   <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            err_flags     <= 4'd0;
            frame_cnt     <= 16'd0;
            last_pix_cnt  <= 12'd0;
            last_line_cnt <= 12'd0;
        end else begin
            r_vs_s1    <= vid.video_vsync;
            r_vs_s2    <= r_vs_s1;
            r_hr_s1    <= vid.video_href;
            r_hr_s2    <= r_hr_s1;
            r_de_s1    <= vid.video_de;
            frame_done <= 1'b0;

            if (w_clear) begin
                r_pix_cnt   <= 12'd0;
                r_line_cnt  <= 12'd0;
                r_err_len   <= 1'b0;
                r_err_stray <= 1'b0;
                r_err_trunc <= 1'b0;
            end else if (w_run) begin
                if (w_line_close) begin
                    r_pix_cnt    <= 12'd0;
                    r_line_cnt   <= w_line_inc;
                    last_pix_cnt <= w_close_len;
                    if (w_close_len != HDISP) begin
                        r_err_len <= 1'b1;
                    end
                    if (w_vs_close) begin
                        r_err_trunc <= 1'b1;
                    end
                end else begin
                    r_pix_cnt <= w_pix_inc;
                end
                if (w_stray) begin
                    r_err_stray <= 1'b1;
                end
            end else if (w_report) begin
                frame_done    <= 1'b1;
                frame_ok      <= ~(r_err_len | w_err_lines | r_err_stray | r_err_trunc);
                err_flags     <= {r_err_trunc, r_err_stray, w_err_lines, r_err_len};
                frame_cnt     <= frame_cnt + 16'd1;
                last_line_cnt <= r_line_cnt;
                // the new frame is already open: keep this cycle's sample
                r_pix_cnt     <= w_pix_acc ? 12'd1 : 12'd0;
                r_line_cnt    <= 12'd0;
                r_err_len     <= 1'b0;
                r_err_stray   <= w_stray;
                r_err_trunc   <= 1'b0;
            end
        end
    end

`ifdef VIDEO_FRAME_MONITOR_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_data_s1;
    logic [31:0]           r_sum;
    logic [31:0]           w_pix_val;

    assign w_pix_val = w_pix_acc ? 32'(r_data_s1) : 32'd0;

    always_ff @(posedge video_clk) begin
        if (rst) begin
            r_data_s1 <= '0;
            r_sum     <= 32'd0;
            frame_sum <= 32'd0;
        end else begin
            r_data_s1 <= vid.video_data;
            if (w_clear) begin
                r_sum <= 32'd0;
            end else if (w_run) begin
                r_sum <= r_sum + w_pix_val;
            end else if (w_report) begin
                frame_sum <= r_sum;
                r_sum     <= w_pix_val;
            end
        end
    end
`else
    assign frame_sum = 32'd0;
`endif

endmodule
